spi_flash_reader: RTL

//  Mode-0 SPI NOR flash read engine: on start, asserts CS, sends READ opcode + 24-bit address,

---
 rtl/spi_flash_pkg.sv | 30 +++
 rtl/spi_sck_gen.sv | 47 ++++
 rtl/spi_flash_reader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_pkg
// Brief    : Opcodes, phase lengths and FSM encoding for the SPI flash reader.
//            FAST_READ_EN selects opcode 0x0B and adds the DUMMY state.
// Revision : 1.0 - initial release
// ============================================================================
package spi_flash_pkg;

    localparam logic [7:0] OPC_READ      = 8'h03;
    localparam logic [7:0] OPC_FAST_READ = 8'h0B;
    localparam int         CMD_BITS      = 8;
    localparam int         ADDR_BITS     = 24;
    localparam int         DUMMY_BITS    = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;
    localparam logic [2:0] ST_END  = 3'd5;
`ifdef FAST_READ_EN
    localparam logic [2:0] ST_DUMMY = 3'd6;
    localparam logic [7:0] OPC_SEL  = OPC_FAST_READ;
`else
    localparam logic [7:0] OPC_SEL  = OPC_READ;
`endif

endpackage
`default_nettype wire

// File: rtl/spi_sck_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_sck_gen
// Brief    : CPOL=0 serial clock divider with enable and edge strobes.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall,
    output logic rise_next
);

    localparam int             CW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] c_cnt_last = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_sck;
    logic          w_due;

    assign w_due = (r_cnt == c_cnt_last);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (w_due) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // rise_next ignores en so the parent can veto an edge without a comb loop
    assign rise_next = w_due && !r_sck;
    assign rise      = en && rise_next;
    assign fall      = en && w_due && r_sck;
    assign sck       = r_sck;

endmodule
`default_nettype wire

// File: rtl/spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_reader
// Brief    : Mode-0 SPI NOR read engine streaming bytes on a valid/ready port.
//            Define FAST_READ_EN for FAST_READ (0x0B) with 8 dummy clocks.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 16,
    parameter int CS_HIGH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [7:0]       data,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             spi_cs_n,
    output logic             spi_sck,
    output logic             spi_mosi,
    input  logic             spi_miso
);

    localparam int            EW         = $clog2(CS_HIGH + 1);
    localparam logic [EW-1:0] c_end_last = EW'(CS_HIGH - 1);

    logic [2:0]       r_state;
    logic [31:0]      r_tx;
    logic [4:0]       r_bit_cnt;
    logic [7:0]       r_rx;
    logic [3:0]       r_rx_cnt;
    logic [LEN_W-1:0] r_rem;
    logic [EW-1:0]    r_end_cnt;
    logic             r_cs_n, r_busy, r_done, r_valid;
    logic [7:0]       r_data;

    logic w_rise, w_fall, w_rise_next, w_sck;
    logic w_free, w_last, w_byte_due, w_stop, w_shifting, w_sck_en;

    assign w_free     = !r_valid || data_ready;
    assign w_last     = (r_rem == LEN_W'(1));
    // A full byte is handed over where the next SCK rise would fall; with
    // CLK_DIV=2 the first data_valid appears 162 edges after the start edge.
    assign w_byte_due = (r_state == ST_DATA) && (r_rx_cnt == 4'd8) && w_rise_next;
    assign w_stop     = w_byte_due && (!w_free || w_last);
`ifdef FAST_READ_EN
    assign w_shifting = (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                        (r_state == ST_DUMMY) || (r_state == ST_DATA);
`else
    assign w_shifting = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_DATA);
`endif
    assign w_sck_en   = w_shifting && !w_stop;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (w_sck_en),
        .sck       (w_sck),
        .rise      (w_rise),
        .fall      (w_fall),
        .rise_next (w_rise_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_tx      <= '0;
            r_bit_cnt <= '0;
            r_rx      <= '0;
            r_rx_cnt  <= '0;
            r_rem     <= '0;
            r_end_cnt <= '0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_valid && data_ready)
                r_valid <= 1'b0;
            // zeros shift in behind the address, so mosi is 0 in dummy/data
            if (w_fall)
                r_tx <= {r_tx[30:0], 1'b0};

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            r_tx      <= {OPC_SEL, addr};
                            r_rem     <= len;
                            r_cs_n    <= 1'b0;
                            r_busy    <= 1'b1;
                            r_bit_cnt <= '0;
                            r_rx_cnt  <= '0;
                            r_state   <= ST_CMD;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_CMD: begin
                    if (w_rise) begin
                        if (r_bit_cnt == 5'(CMD_BITS - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= ST_ADDR;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_rise) begin
                        if (r_bit_cnt == 5'(ADDR_BITS - 1)) begin
                            r_bit_cnt <= '0;
`ifdef FAST_READ_EN
                            r_state   <= ST_DUMMY;
`else
                            r_state   <= ST_DATA;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                end
`ifdef FAST_READ_EN
                ST_DUMMY: begin
                    if (w_rise) begin
                        if (r_bit_cnt == 5'(DUMMY_BITS - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= ST_DATA;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                end
`endif
                ST_DATA: begin
                    if (w_byte_due) begin
                        if (w_free) begin
                            r_data  <= r_rx;
                            r_valid <= 1'b1;
                            r_rem   <= r_rem - LEN_W'(1);
                            if (w_last) begin
                                r_cs_n    <= 1'b1;
                                r_end_cnt <= '0;
                                r_state   <= ST_END;
                            end else begin
                                r_rx     <= {r_rx[6:0], spi_miso};
                                r_rx_cnt <= 4'd1;
                            end
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end else if (w_rise) begin
                        r_rx     <= {r_rx[6:0], spi_miso};
                        r_rx_cnt <= r_rx_cnt + 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (w_free) begin
                        r_data  <= r_rx;
                        r_valid <= 1'b1;
                        r_rem   <= r_rem - LEN_W'(1);
                        if (w_last) begin
                            r_cs_n    <= 1'b1;
                            r_end_cnt <= '0;
                            r_state   <= ST_END;
                        end else begin
                            r_rx_cnt <= '0;
                            r_state  <= ST_DATA;
                        end
                    end
                end
                ST_END: begin
                    if (r_end_cnt == c_end_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_end_cnt <= r_end_cnt + EW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign data       = r_data;
    assign data_valid = r_valid;
    assign spi_cs_n   = r_cs_n;
    assign spi_sck    = w_sck;
    assign spi_mosi   = r_tx[31];

endmodule
`default_nettype wire
